alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 126 ++++++++++++
 tb/tb_alu_multicycle.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle ALU ops plus an iterative shift-add multiplier.
// out/flags are registered and change only on the cycle done pulses.
module alu_multicycle #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        operation,
    input  logic [DWIDTH-1:0] operand1,
    input  logic [DWIDTH-1:0] operand2,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] out,
    output logic              Z,
    output logic              C,
    output logic              N
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam int CW = $clog2(DWIDTH);
    logic [1:0]          state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DWIDTH-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DWIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_next;
    logic                z_q, z_d, c_q, c_d, n_q, n_d, done_q, done_d;
    logic [DWIDTH-1:0]   res, fres;
    logic                cy, fc;
    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (op_q)
            4'b0000: res = a_q;
            4'b0001: {cy, res} = {1'b0, a_q} + {1'b0, b_q};
            4'b0010: {cy, res} = {1'b0, a_q} - {1'b0, b_q};
            4'b0011: {cy, res} = {a_q[DWIDTH-1], a_q << 1};
            4'b0100: {cy, res} = {a_q[DWIDTH-2], a_q << 2};
            4'b0101: {cy, res} = {a_q[3], a_q >> 4};
            4'b0110: {cy, res} = {1'b0, a_q} + (DWIDTH+1)'(1);
            4'b0111: res = a_q & b_q;
            4'b1000: res = a_q | b_q;
            4'b1001: res = a_q ^ b_q;
            4'b1010: {cy, res} = {1'b0, a_q} - (DWIDTH+1)'(1);
            default: res = '0;
        endcase
    end
    // Multiplier consumes the LSB of b_q each cycle while the multiplicand shifts left.
    assign prod_next = prod_q + (b_q[0] ? mcand_q : '0);
    assign fres = state_q == MUL ? prod_next[DWIDTH-1:0] : res;
    assign fc   = state_q == MUL ? |prod_next[2*DWIDTH-1:DWIDTH] : cy;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        out_d   = out_q;
        z_d     = z_q;
        c_d     = c_q;
        n_d     = n_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            op_d    = operation;
            a_d     = operand1;
            b_d     = operand2;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{DWIDTH{1'b0}}, operand1};
            state_d = operation == 4'b1011 ? MUL : EXEC;
        end else if (state_q == MUL) begin
            prod_d  = prod_next;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
        end
        if (state_q == EXEC || (state_q == MUL && cnt_q == CW'(DWIDTH-1))) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = fres;
            z_d     = fres == '0;
            c_d     = fc;
            n_d     = fres[DWIDTH-1];
            done_d  = 1'b1;
        end
        if (state_q != IDLE && state_q != EXEC && state_q != MUL) state_d = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            out_q   <= '0;
            z_q     <= 1'b1;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            out_q   <= out_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign out  = out_q;
    assign Z    = z_q;
    assign C    = c_q;
    assign N    = n_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed scenario tasks with hand-computed expectations.
module tb_alu_multicycle;
    localparam int W = 16;
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, r;
        logic         c;
    } vec_t;
    logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [3:0]   operation = 4'h0;
    logic [W-1:0] operand1 = '0, operand2 = '0;
    logic         busy, done, Z, C, N;
    logic [W-1:0] out;
    int           checks = 0, errors = 0;
    vec_t         vecs[14];

    alu_multicycle #(.DWIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .operation(operation),
        .operand1(operand1), .operand2(operand2), .busy(busy), .done(done),
        .out(out), .Z(Z), .C(C), .N(N)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; operation = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out, Z, C, N, busy, done} !== {16'h0000, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", {out, Z, C, N, busy, done}, {16'h0000, 1'b1, 4'b0000});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_alu_ops;
        vecs = '{
            '{4'b0000, 16'h1234, 16'h0000, 16'h1234, 1'b0},
            '{4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1},
            '{4'b0010, 16'h0003, 16'h0005, 16'hFFFE, 1'b1},
            '{4'b0101, 16'h1238, 16'h0000, 16'h0123, 1'b1},
            '{4'b0011, 16'h8001, 16'h0000, 16'h0002, 1'b1},
            '{4'b0100, 16'h4001, 16'h0000, 16'h0004, 1'b1},
            '{4'b0111, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0},
            '{4'b1000, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0},
            '{4'b1001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0},
            '{4'b1010, 16'h0000, 16'h0000, 16'hFFFF, 1'b1},
            '{4'b0110, 16'h1234, 16'h0000, 16'h1235, 1'b0},
            '{4'b1111, 16'hABCD, 16'h0000, 16'h0000, 1'b0},
            '{4'b1100, 16'h1234, 16'h5678, 16'h0000, 1'b0},
            '{4'b0001, 16'h1234, 16'h4321, 16'h5555, 1'b0}
        };
        foreach (vecs[i]) begin
            do_start(vecs[i].op, vecs[i].a, vecs[i].b);
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL op%0d_busy got %b exp %b", i, {busy, done}, 2'b10);
            end
            @(posedge clk); #1;
            checks++;
            if ({out, Z, C, N, done, busy} !== {vecs[i].r, vecs[i].r == '0, vecs[i].c, vecs[i].r[W-1], 2'b10}) begin
                errors++;
                $display("FAIL op%0d_result got %h exp %h", i, {out, Z, C, N, done, busy},
                         {vecs[i].r, vecs[i].r == '0, vecs[i].c, vecs[i].r[W-1], 2'b10});
            end
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        operation = 4'b0001; operand1 = 16'h0F0F; operand2 = 16'h0101;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out, Z, C, N, done, busy} !== {16'h5555, 5'b00000}) begin
            errors++;
            $display("FAIL hold got %h exp %h", {out, Z, C, N, done, busy}, {16'h5555, 5'b00000});
        end
    endtask

    task automatic test_back_to_back;
        do_start(4'b0001, 16'h0001, 16'h0002);
        start = 1'b1; operation = 4'b1001; operand1 = 16'h00FF; operand2 = 16'h0F0F;
        @(posedge clk); #1;
        checks++;
        if ({out, done, busy} !== {16'h0003, 2'b10}) begin
            errors++;
            $display("FAIL b2b_first got %h exp %h", {out, done, busy}, {16'h0003, 2'b10});
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_accept got %b exp %b", {done, busy}, 2'b01);
        end
        @(posedge clk); #1;
        checks++;
        if ({out, Z, C, N, done, busy} !== {16'h0FF0, 5'b00010}) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", {out, Z, C, N, done, busy}, {16'h0FF0, 5'b00010});
        end
    endtask

    task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r, input logic c);
        logic [W-1:0] prev;
        int n, bcnt, hold_bad;
        prev = out;
        hold_bad = 0;
        n = 0;
        do_start(4'b1011, a, b);
        bcnt = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) bcnt++;
            if (!done && out !== prev) hold_bad++;
        end
        checks++;
        if (n !== 16 || bcnt !== 16) begin
            errors++;
            $display("FAIL mul_latency got edges %0d busy %0d exp edges 16 busy 16", n, bcnt);
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL mul_hold got %0d exp 0", hold_bad);
        end
        checks++;
        if ({out, Z, C, N, done, busy} !== {r, r == '0, c, r[W-1], 2'b10}) begin
            errors++;
            $display("FAIL mul_result got %h exp %h", {out, Z, C, N, done, busy}, {r, r == '0, c, r[W-1], 2'b10});
        end
    endtask

    task automatic test_mul_ignore_start;
        int dones;
        logic [W-1:0] seen;
        dones = 0;
        seen = '0;
        do_start(4'b1011, 16'h0003, 16'h0004);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; operation = 4'b0001; operand1 = 16'h0001; operand2 = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                seen = out;
            end
        end
        checks++;
        if (dones !== 1 || seen !== 16'h000C || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_ignore got dones %0d out %h busy %b exp dones 1 out 000c busy 0", dones, seen, busy);
        end
    endtask

    task automatic test_reset_mid_mul;
        int dones;
        dones = 0;
        do_start(4'b1011, 16'h0012, 16'h0034);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out, Z, C, N, busy, done} !== {16'h0000, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL rst_mid_mul got %h exp %h", {out, Z, C, N, busy, done}, {16'h0000, 1'b1, 4'b0000});
        end
        @(negedge clk); rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done got dones %0d busy %b exp 0 0", dones, busy);
        end
        do_start(4'b0110, 16'h7FFF, 16'h0000);
        @(posedge clk); #1;
        checks++;
        if ({out, Z, C, N, done, busy} !== {16'h8000, 5'b00110}) begin
            errors++;
            $display("FAIL inc_after_rst got %h exp %h", {out, Z, C, N, done, busy}, {16'h8000, 5'b00110});
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_hold();
        test_back_to_back();
        test_mul(16'h0012, 16'h0034, 16'h03A8, 1'b0);
        test_mul(16'h0100, 16'h0100, 16'h0000, 1'b1);
        test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
        test_mul_ignore_start();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
